uart_tx_ctrl: RTL and testbench
===============================

# uart_tx_ctrl

Frame controller and serializer for the UART transmitter. It sits directly upstream of the TX output mux. It accepts a parallel byte with a valid strobe, then sequences start, data (LSB first), optional parity and stop bits by driving the mux select, serial data and parity bit. One CLK cycle equals one bit period; the clock is the baud-rate clock.

## Interface
Parameters:
- DATA_WIDTH, 8: payload bits per frame; bit counter width is clog2(DATA_WIDTH).

Ports:
- CLK  input  1  baud-rate clock; all state changes on rising edge.
- RST  input  1  asynchronous, active-low reset.
- P_DATA  input  DATA_WIDTH  parallel payload; sampled only on acceptance.
- Data_Valid  input  1  payload request; accepted only while IDLE.
- PAR_EN  input  1  1 = insert parity bit; sampled on acceptance.
- PAR_TYP  input  1  0 = even, 1 = odd; sampled on acceptance.
- mux_sel  output  2  00 start, 01 stop/idle, 10 serial data, 11 parity.
- Ser_data  output  1  current data bit, valid while mux_sel = 10.
- par_bit  output  1  parity of the latched payload; stable for the whole frame.
- Busy  output  1  high from START through STOP inclusive.

## Operation
- FSM states: IDLE, START, DATA, PARITY, STOP. All outputs decode from registers, with no combinational path from inputs.
- IDLE: mux_sel = 01, Busy = 0.
  - Data_Valid = 1 at a rising edge triggers acceptance:
    - latch P_DATA into the shift register;
    - latch PAR_EN and PAR_TYP;
    - register par_bit;
    - go to START.
- START: mux_sel = 00, Busy = 1; next state is DATA; bit counter cleared.
- DATA: mux_sel = 10, Ser_data = shift_reg[0].
  - Each edge shifts right and increments the counter.
  - After DATA_WIDTH cycles, go to PARITY if the latched PAR_EN = 1, else STOP.
- PARITY: mux_sel = 11 for one cycle, then STOP.
- STOP: mux_sel = 01, Busy = 1 for one cycle, then IDLE unconditionally.
  - The minimum inter-frame gap is one IDLE cycle, which appears on the line as an extra stop bit.
- Parity computation:
  - even: par_bit = XOR of all latched payload bits;
  - odd: par_bit = its inverse.
- Data_Valid, P_DATA, PAR_EN and PAR_TYP are ignored outside IDLE.
  - Input changes mid-frame have no effect on the frame in flight.
- Handshake: upstream holds Data_Valid until it sees Busy rise.
  - A Data_Valid still high when the FSM returns to IDLE starts a new frame. This is the intended back-to-back behaviour.
- Bit counter: no wrap; it is cleared in START and saturates logic at DATA_WIDTH-1 → exit.

## Timing
- Reset (RST low, asynchronous):
  - state = IDLE, mux_sel = 01;
  - Ser_data = 0, par_bit = 0, Busy = 0;
  - shift register and counter = 0.
- Reset asserted mid-frame aborts the frame immediately. The line returns to idle-high via the downstream mux reset.
- Acceptance at edge k gives the following sequence:
  - START during cycle k+1;
  - data bit i during cycle k+2+i;
  - parity (if enabled) during cycle k+2+DATA_WIDTH;
  - STOP in the cycle after the last data or parity bit;
  - IDLE in the cycle after STOP.
- Frame length: DATA_WIDTH+2 cycles, or DATA_WIDTH+3 with parity. With DATA_WIDTH = 8 that is 10 or 11 cycles of Busy high.
- The downstream mux registers its output, so the serial line lags mux_sel/Ser_data by one cycle. This controller does not compensate.
- Busy rises in cycle k+1 and falls in the first IDLE cycle.

## Test plan
- 0xA5, PAR_EN = 0:
  - mux_sel sequence 01,00,10×8,01,01;
  - Ser_data bits 1,0,1,0,0,1,0,1;
  - Busy high exactly 10 cycles.
- 0xA5, PAR_EN = 1, PAR_TYP = 0: par_bit = 0; mux_sel 11 appears once, after the 8th data bit; Busy high 11 cycles.
- 0x01, PAR_EN = 1, PAR_TYP = 1: par_bit = 0. 0x03 with odd parity gives par_bit = 1.
- Data_Valid pulsed with 0x3C during DATA of a 0xF0 frame: the frame completes as 0xF0 and no second frame starts.
- Data_Valid held high with constant 0x55: consecutive frames are separated by exactly one IDLE cycle (mux_sel = 01, Busy = 0).
- RST dropped during data bit 4, then released:
  - outputs go to reset values asynchronously;
  - FSM is in IDLE;
  - the next Data_Valid produces a complete, correct frame.

Source files
------------

// File: rtl/uart_tx_ctrl.sv
// UART transmit frame controller: accepts a parallel word, then sequences
// start, LSB-first data, optional parity and stop by driving the TX mux select.
module uart_tx_ctrl #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  Data_Valid,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  output logic [1:0]            mux_sel,
  output logic                  Ser_data,
  output logic                  par_bit,
  output logic                  Busy
);

  localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH - 1);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;

  localparam logic [1:0] SEL_START  = 2'b00;
  localparam logic [1:0] SEL_STOP   = 2'b01;
  localparam logic [1:0] SEL_DATA   = 2'b10;
  localparam logic [1:0] SEL_PARITY = 2'b11;

  logic [2:0]            r_state;
  logic [2:0]            w_state_nxt;
  logic [1:0]            r_mux_sel;
  logic                  r_busy;
  logic [DATA_WIDTH-1:0] r_shift;
  logic [CNT_W-1:0]      r_cnt;
  logic                  r_par_en;
  logic                  r_par_bit;
  logic                  w_accept;

  function automatic logic calc_parity(input logic [DATA_WIDTH-1:0] data,
                                       input logic odd);
    return (^data) ^ odd;
  endfunction

  function automatic logic [1:0] sel_for(input logic [2:0] st);
    logic [1:0] sel;
    case (st)
      ST_START:  sel = SEL_START;
      ST_DATA:   sel = SEL_DATA;
      ST_PARITY: sel = SEL_PARITY;
      ST_STOP:   sel = SEL_STOP;
      default:   sel = SEL_STOP;
    endcase
    return sel;
  endfunction

  assign w_accept = (r_state == ST_IDLE) && Data_Valid;

  // Next-state selection for the frame sequencer.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (Data_Valid) w_state_nxt = ST_START;
        else            w_state_nxt = ST_IDLE;
      end
      ST_START: w_state_nxt = ST_DATA;
      ST_DATA: begin
        if (r_cnt == CNT_LAST) w_state_nxt = r_par_en ? ST_PARITY : ST_STOP;
        else                   w_state_nxt = ST_DATA;
      end
      ST_PARITY: w_state_nxt = ST_STOP;
      ST_STOP:   w_state_nxt = ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  // State plus select/busy, registered from the next state so they line up
  // with the state they describe.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state   <= ST_IDLE;
      r_mux_sel <= SEL_STOP;
      r_busy    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_mux_sel <= sel_for(w_state_nxt);
      r_busy    <= (w_state_nxt != ST_IDLE);
    end
  end

  // Payload shift register, bit counter and per-frame parity settings.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_shift   <= '0;
      r_cnt     <= '0;
      r_par_en  <= 1'b0;
      r_par_bit <= 1'b0;
    end else if (w_accept) begin
      r_shift   <= P_DATA;
      r_par_en  <= PAR_EN;
      r_par_bit <= calc_parity(P_DATA, PAR_TYP);
    end else if (r_state == ST_START) begin
      r_cnt <= '0;
    end else if (r_state == ST_DATA) begin
      r_shift <= r_shift >> 1;
      // Counter parks on the last index; the FSM leaves DATA there.
      if (r_cnt != CNT_LAST) r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign mux_sel  = r_mux_sel;
  assign Ser_data = r_shift[0];
  assign par_bit  = r_par_bit;
  assign Busy     = r_busy;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Directed + randomized bench for uart_tx_ctrl; expected per-cycle line
// activity is built from the frame rules as queues.
module tb_uart_tx_ctrl;

  logic       CLK = 1'b0;
  logic       RST;
  logic [7:0] P_DATA;
  logic       Data_Valid;
  logic       PAR_EN;
  logic       PAR_TYP;
  logic [1:0] mux_sel;
  logic       Ser_data;
  logic       par_bit;
  logic       Busy;

  int n_cmp = 0;
  int n_err = 0;

  logic [1:0] q_sel[$];
  logic       q_ser[$];
  logic       q_busy[$];
  logic       exp_par;

  uart_tx_ctrl #(.DATA_WIDTH(8)) dut (
    .CLK(CLK), .RST(RST), .P_DATA(P_DATA), .Data_Valid(Data_Valid),
    .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP), .mux_sel(mux_sel),
    .Ser_data(Ser_data), .par_bit(par_bit), .Busy(Busy)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected line activity per cycle after acceptance: start, data LSB first,
  // optional parity, stop, then one idle cycle.
  function automatic void build(input logic [7:0] d, input logic pe, input logic pt);
    q_sel.delete(); q_ser.delete(); q_busy.delete();
    q_sel.push_back(2'b00); q_ser.push_back(1'b0); q_busy.push_back(1'b1);
    for (int i = 0; i < 8; i++) begin
      q_sel.push_back(2'b10); q_ser.push_back(d[i]); q_busy.push_back(1'b1);
    end
    if (pe) begin
      q_sel.push_back(2'b11); q_ser.push_back(1'b0); q_busy.push_back(1'b1);
    end
    q_sel.push_back(2'b01); q_ser.push_back(1'b0); q_busy.push_back(1'b1);
    q_sel.push_back(2'b01); q_ser.push_back(1'b0); q_busy.push_back(1'b0);
    exp_par = 1'b0;
    for (int i = 0; i < 8; i++) exp_par = exp_par ^ d[i];
    exp_par = exp_par ^ pt;
  endfunction

  // Called at a negedge while the DUT is idle; the next posedge accepts.
  task automatic run_frame(input logic [7:0] d, input logic pe, input logic pt,
                           input bit keep, input int inject);
    P_DATA = d; PAR_EN = pe; PAR_TYP = pt; Data_Valid = 1'b1;
    build(d, pe, pt);
    for (int j = 0; j < q_sel.size(); j++) begin
      @(negedge CLK);
      chk($sformatf("sel[%0d] d=%0h", j, d), 8'(mux_sel), 8'(q_sel[j]));
      chk($sformatf("busy[%0d] d=%0h", j, d), 8'(Busy), 8'(q_busy[j]));
      chk($sformatf("par[%0d] d=%0h", j, d), 8'(par_bit), 8'(exp_par));
      if (q_sel[j] == 2'b10)
        chk($sformatf("ser[%0d] d=%0h", j, d), 8'(Ser_data), 8'(q_ser[j]));
      if (!keep) begin
        if (j == 0) begin
          Data_Valid = 1'b0;
          P_DATA = 8'($urandom); PAR_EN = 1'($urandom); PAR_TYP = 1'($urandom);
        end
        if (j == inject) begin
          Data_Valid = 1'b1; P_DATA = 8'h3C; PAR_EN = ~pe;
        end
        if (j == inject + 2) Data_Valid = 1'b0;
      end
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, " sel"}, 8'(mux_sel), 8'h01);
    chk({tag, " busy"}, 8'(Busy), 8'h00);
  endtask

  initial begin
    logic [7:0] d;
    logic pe, pt;
    RST = 1'b0; P_DATA = 8'h00; Data_Valid = 1'b0; PAR_EN = 1'b0; PAR_TYP = 1'b0;
    repeat (2) @(negedge CLK);
    chk_idle("reset");
    chk("reset ser", 8'(Ser_data), 8'h00);
    chk("reset par", 8'(par_bit), 8'h00);
    RST = 1'b1;
    repeat (2) begin
      @(negedge CLK);
      chk_idle("post-reset idle");
    end

    run_frame(8'hA5, 1'b0, 1'b0, 1'b0, -10);
    run_frame(8'hA5, 1'b1, 1'b0, 1'b0, -10);
    run_frame(8'h01, 1'b1, 1'b1, 1'b0, -10);
    run_frame(8'h03, 1'b1, 1'b1, 1'b0, -10);

    // Data_Valid pulse with 0x3C during DATA must not disturb or follow the frame.
    pe = 1'($urandom); pt = 1'($urandom);
    run_frame(8'hF0, pe, pt, 1'b0, 3);
    repeat (3) begin
      @(negedge CLK);
      chk_idle("no second frame");
    end

    // Held Data_Valid: frames back to back with exactly one idle cycle.
    pe = 1'($urandom); pt = 1'($urandom);
    run_frame(8'h55, pe, pt, 1'b1, -10);
    run_frame(8'h55, pe, pt, 1'b1, -10);
    run_frame(8'h55, pe, pt, 1'b0, -10);
    @(negedge CLK);
    chk_idle("after back-to-back");

    for (int n = 0; n < 20; n++) begin
      d = 8'($urandom); pe = 1'($urandom); pt = 1'($urandom);
      run_frame(d, pe, pt, 1'b0, -10);
    end

    // Reset during data bit 4.
    d = 8'($urandom); pe = 1'b1; pt = 1'($urandom);
    P_DATA = d; PAR_EN = pe; PAR_TYP = pt; Data_Valid = 1'b1;
    for (int j = 0; j < 6; j++) begin
      @(negedge CLK);
      if (j == 0) Data_Valid = 1'b0;
    end
    chk("abort pre sel", 8'(mux_sel), 8'h02);
    chk("abort pre ser", 8'(Ser_data), 8'(d[4]));
    #2 RST = 1'b0;
    #1;
    chk_idle("async reset");
    chk("async reset ser", 8'(Ser_data), 8'h00);
    chk("async reset par", 8'(par_bit), 8'h00);
    @(negedge CLK);
    chk_idle("held reset");
    RST = 1'b1;
    @(negedge CLK);
    chk_idle("after abort");
    d = 8'($urandom); pe = 1'($urandom); pt = 1'($urandom);
    run_frame(d, pe, pt, 1'b0, -10);
    @(negedge CLK);
    chk_idle("final");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
